// File: rtl/dpm_feed_tx_if.sv
// Bundle of the feature/offset sources, DPM FIFO write port and prefetch-SRAM ref bus
// seen by dpm_feed_tx; slave is the transmitter's view, master the environment's.
interface dpm_feed_tx_if #(
   parameter int DATA_W = 16,
   parameter int REF_AW = 8
);
   logic              start;
   logic              bypass_mode;
   logic [DATA_W-1:0] feat_in;
   logic              feat_in_valid;
   logic              feat_in_ready;
   logic [DATA_W-1:0] off_in;
   logic              off_in_valid;
   logic              off_in_ready;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              fifo_wr_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic              ref_rd_en;
   logic [REF_AW-1:0] ref_rd_addr;
   logic [DATA_W-1:0] ref_rd_data;
   logic [DATA_W-1:0] ref_data;
   logic              ref_data_valid;
   logic              busy;
   logic              done;

   modport slave (
      input  start, bypass_mode, feat_in, feat_in_valid, off_in, off_in_valid,
             fifo_full, fifo_empty, ref_rd_data,
      output feat_in_ready, off_in_ready, fifo_wr_data, fifo_wr_en,
             ref_rd_en, ref_rd_addr, ref_data, ref_data_valid, busy, done
   );

   modport master (
      output start, bypass_mode, feat_in, feat_in_valid, off_in, off_in_valid,
             fifo_full, fifo_empty, ref_rd_data,
      input  feat_in_ready, off_in_ready, fifo_wr_data, fifo_wr_en,
             ref_rd_en, ref_rd_addr, ref_data, ref_data_valid, busy, done
   );
endinterface

// File: rtl/dpm_feed_tx.sv
// Per-tile transmitter feeding dpm: 16 features and 18 offsets into the DPM FIFO, then
// a 256-pixel ref stream from prefetch SRAM once dpm has drained the FIFO.
module dpm_feed_tx #(
   parameter int DATA_W       = 16,
   parameter int GROUP_ROWS   = 4,
   parameter int KERNEL_SIZE  = 3,
   parameter int REF_BUF_SIZE = 16,
   parameter int REF_AW       = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   dpm_feed_tx_if.slave tx_io
);
   localparam int FEAT_N  = GROUP_ROWS * GROUP_ROWS;
   localparam int OFF_N   = 2 * KERNEL_SIZE * KERNEL_SIZE;
   localparam int REF_N   = REF_BUF_SIZE * REF_BUF_SIZE;
   localparam int FEAT_CW = $clog2(FEAT_N);
   localparam int OFF_CW  = $clog2(OFF_N);
   localparam logic [FEAT_CW-1:0] FEAT_LAST = FEAT_CW'(FEAT_N - 1);
   localparam logic [OFF_CW-1:0]  OFF_LAST  = OFF_CW'(OFF_N - 1);
   localparam logic [REF_AW-1:0]  REF_LAST  = REF_AW'(REF_N - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FEAT  = 3'd1,
      S_OFF   = 3'd2,
      S_DRAIN = 3'd3,
      S_GAP   = 3'd4,
      S_REF   = 3'd5,
      S_FLUSH = 3'd6,
      S_DONE  = 3'd7
   } state_e;

   state_e              state_q;
   logic [FEAT_CW-1:0]  feat_cnt_q;
   logic [OFF_CW-1:0]   off_cnt_q;
   logic [REF_AW-1:0]   ref_addr_q;
   logic                bypass_q;
   logic                ref_rd_en_q;
   logic                ref_valid_q;
   logic                busy_q;
   logic                done_q;

   logic                push_s;
   logic                feat_rdy_s;
   logic                off_rdy_s;
   logic [DATA_W-1:0]   wr_data_s;

   // FIFO write port: zero-latency pass-through of the active source, stalled by fifo_full
   always_comb begin
      push_s     = 1'b0;
      feat_rdy_s = 1'b0;
      off_rdy_s  = 1'b0;
      wr_data_s  = {DATA_W{1'b0}};
      case (state_q)
         S_FEAT: begin
            feat_rdy_s = !tx_io.fifo_full;
            push_s     = tx_io.feat_in_valid & !tx_io.fifo_full;
            wr_data_s  = tx_io.feat_in;
         end
         S_OFF: begin
            // bypass still emits a full offset frame of zeros so dpm's word count never changes
            if (bypass_q) begin
               push_s = !tx_io.fifo_full;
            end else begin
               off_rdy_s = !tx_io.fifo_full;
               push_s    = tx_io.off_in_valid & !tx_io.fifo_full;
               wr_data_s = tx_io.off_in;
            end
         end
         default: begin
            push_s = 1'b0;
         end
      endcase
   end

   // Tile sequencer: phase, word counters and the registered ref-bus/status strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         feat_cnt_q  <= {FEAT_CW{1'b0}};
         off_cnt_q   <= {OFF_CW{1'b0}};
         ref_addr_q  <= {REF_AW{1'b0}};
         bypass_q    <= 1'b0;
         ref_rd_en_q <= 1'b0;
         ref_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         ref_valid_q <= ref_rd_en_q;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tx_io.start) begin
                  state_q    <= S_FEAT;
                  busy_q     <= 1'b1;
                  bypass_q   <= tx_io.bypass_mode;
                  feat_cnt_q <= {FEAT_CW{1'b0}};
                  off_cnt_q  <= {OFF_CW{1'b0}};
               end
            end
            S_FEAT: begin
               if (push_s) begin
                  if (feat_cnt_q == FEAT_LAST) begin
                     feat_cnt_q <= {FEAT_CW{1'b0}};
                     state_q    <= S_OFF;
                  end else begin
                     feat_cnt_q <= feat_cnt_q + FEAT_CW'(1);
                  end
               end
            end
            S_OFF: begin
               if (push_s) begin
                  if (off_cnt_q == OFF_LAST) begin
                     off_cnt_q <= {OFF_CW{1'b0}};
                     state_q   <= S_DRAIN;
                  end else begin
                     off_cnt_q <= off_cnt_q + OFF_CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (tx_io.fifo_empty) begin
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               state_q     <= S_REF;
               ref_rd_en_q <= 1'b1;
               ref_addr_q  <= {REF_AW{1'b0}};
            end
            S_REF: begin
               // dpm's ref bus has no backpressure: one read per cycle, address wraps after the last
               ref_addr_q <= ref_addr_q + REF_AW'(1);
               if (ref_addr_q == REF_LAST) begin
                  ref_rd_en_q <= 1'b0;
                  state_q     <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               ref_rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_io.feat_in_ready  = feat_rdy_s;
   assign tx_io.off_in_ready   = off_rdy_s;
   assign tx_io.fifo_wr_en     = push_s;
   assign tx_io.fifo_wr_data   = wr_data_s;
   assign tx_io.ref_rd_en      = ref_rd_en_q;
   assign tx_io.ref_rd_addr    = ref_addr_q;
   assign tx_io.ref_data       = tx_io.ref_rd_data;
   assign tx_io.ref_data_valid = ref_valid_q;
   assign tx_io.busy           = busy_q;
   assign tx_io.done           = done_q;
endmodule

// File: tb/tb_dpm_feed_tx.sv
// Randomized bench for dpm_feed_tx: a per-tile timeline model predicts every output each
// cycle, and per-tile literal totals pin the model to the hand-derived tile timing.
module tb_dpm_feed_tx;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dpm_feed_tx_if #(.DATA_W(16), .REF_AW(8)) bus ();

   dpm_feed_tx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_io (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   int feat_arr [16];
   int off_arr  [18];
   int salt = 0;

   // model: expected tile timeline
   bit m_tile = 1'b0;
   bit m_byp  = 1'b0;
   int m_push = 0;
   int m_t0   = -1;
   int m_salt = 0;

   // tallies of what the DUT actually did
   int n_wr = 0, n_refv = 0, n_done = 0, n_fall = 0, n_offrdy = 0, n_zero = 0;
   int last_push_cyc = 0, first_ref_cyc = 0, done_cyc = 0, first_word = 0;
   bit prev_busy = 1'b0, prev_ren = 1'b0, got_first = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic int sram_f(input int a, input int s);
      return (a ^ s) & 32'hFFFF;
   endfunction

   function automatic int exp_word(input int k, input bit byp);
      if (k < 16) return feat_arr[k];
      else if (byp) return 0;
      else return off_arr[k - 16];
   endfunction

   // SRAM responder: data for a read strobed in one cycle appears in the next
   initial begin
      logic       pend_en;
      logic [7:0] pend_a;
      forever begin
         @(negedge clk);
         pend_en = bus.ref_rd_en;
         pend_a  = bus.ref_rd_addr;
         @(posedge clk);
         #1;
         if (pend_en === 1'b1) bus.ref_rd_data = 16'(sram_f(int'(pend_a), salt));
      end
   end

   // compare process: every cycle, outputs against the tile timeline
   always @(negedge clk) begin
      int e_busy, e_wr, e_fr, e_or, e_ren, e_rv, e_done, e_addr, e_rdata, k;
      e_busy = 0; e_wr = 0; e_fr = 0; e_or = 0; e_ren = 0; e_rv = 0; e_done = 0;
      e_addr = 0; e_rdata = 0; k = 0;
      if (!rst_n) begin
         chk("rst_busy",      int'(bus.busy), 0);
         chk("rst_done",      int'(bus.done), 0);
         chk("rst_wr_en",     int'(bus.fifo_wr_en), 0);
         chk("rst_feat_rdy",  int'(bus.feat_in_ready), 0);
         chk("rst_off_rdy",   int'(bus.off_in_ready), 0);
         chk("rst_ref_rd_en", int'(bus.ref_rd_en), 0);
         chk("rst_ref_valid", int'(bus.ref_data_valid), 0);
         chk("rst_ref_addr",  int'(bus.ref_rd_addr), 0);
         m_tile = 1'b0; m_push = 0; m_t0 = -1;
         prev_busy = 1'b0; prev_ren = 1'b0;
      end else begin
         e_busy = int'(m_tile);
         if (m_tile) begin
            if (m_push < 34) begin
               if (m_push < 16) begin
                  e_fr = int'(!bus.fifo_full);
                  e_wr = int'(!bus.fifo_full && bus.feat_in_valid);
               end else begin
                  e_or = int'(!bus.fifo_full && !m_byp);
                  e_wr = int'(!bus.fifo_full && (m_byp || bus.off_in_valid));
               end
            end else begin
               if (m_t0 < 0 && bus.fifo_empty) m_t0 = cyc + 2;
               if (m_t0 >= 0) begin
                  k       = cyc - m_t0;
                  e_ren   = int'(k >= 0 && k < 256);
                  e_addr  = (e_ren != 0) ? k : 0;
                  e_rv    = int'(k >= 1 && k <= 256);
                  e_rdata = sram_f(k - 1, m_salt);
                  e_done  = int'(k == 257);
               end
            end
         end
         chk("busy",           int'(bus.busy), e_busy);
         chk("fifo_wr_en",     int'(bus.fifo_wr_en), e_wr);
         chk("feat_in_ready",  int'(bus.feat_in_ready), e_fr);
         chk("off_in_ready",   int'(bus.off_in_ready), e_or);
         chk("ref_rd_en",      int'(bus.ref_rd_en), e_ren);
         chk("ref_rd_addr",    int'(bus.ref_rd_addr), e_addr);
         chk("ref_data_valid", int'(bus.ref_data_valid), e_rv);
         chk("done",           int'(bus.done), e_done);
         if (e_wr != 0) chk("fifo_wr_data", int'(bus.fifo_wr_data), exp_word(m_push, m_byp));
         if (e_rv != 0) chk("ref_data", int'(bus.ref_data), e_rdata);

         if (bus.busy && !prev_busy) got_first = 1'b0;
         if (bus.fifo_wr_en) begin
            n_wr++;
            last_push_cyc = cyc;
            if (bus.fifo_wr_data == 16'h0000) n_zero++;
            if (!got_first) begin
               got_first  = 1'b1;
               first_word = int'(bus.fifo_wr_data);
            end
         end
         if (bus.off_in_ready) n_offrdy++;
         if (bus.ref_data_valid) n_refv++;
         if (bus.ref_rd_en && !prev_ren) first_ref_cyc = cyc;
         if (bus.done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (!bus.busy && prev_busy) n_fall++;
         prev_busy = bus.busy;
         prev_ren  = bus.ref_rd_en;

         if (e_wr != 0) m_push++;
         if (e_done != 0) begin
            m_tile = 1'b0;
         end else if (e_busy == 0 && bus.start) begin
            m_tile = 1'b1; m_push = 0; m_t0 = -1;
            m_byp  = bus.bypass_mode;
            m_salt = salt;
         end
      end
   end

   task automatic drive_src(input int fi, input int oi, input bit pat);
      bus.feat_in       = 16'(feat_arr[fi < 16 ? fi : 15]);
      bus.feat_in_valid = pat ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.off_in        = 16'(off_arr[oi < 18 ? oi : 17]);
      bus.off_in_valid  = pat ? 1'b1 : ($urandom_range(0, 3) != 0);
   endtask

   // one tile: byp=bypass, pat=fixed data pattern, full_pct=random fifo_full rate,
   // bp=two 3-cycle full holds, hold=fifo_empty delay, t6=stray starts, abort_at=reset after N ref pixels
   task automatic run_tile(input bit byp, input bit pat, input int full_pct, input bit bp,
                           input int hold, input bit t6, input int abort_at);
      int fi, oi, n, pushes, full_left, empty_cyc, start_cyc;
      int b_wr, b_rv, b_done, b_fall, b_or, b_zero;
      bit hsf, hso, f5, f20, mid_fired, fin, aborted;
      fi = 0; oi = 0; n = 0; pushes = 0; full_left = 0; empty_cyc = -1;
      f5 = 1'b0; f20 = 1'b0; mid_fired = 1'b0; fin = 1'b0; aborted = 1'b0;
      salt = pat ? 0 : int'($urandom_range(0, 65535));
      for (int i = 0; i < 16; i++) feat_arr[i] = pat ? i + 1 : int'($urandom_range(0, 65535));
      for (int i = 0; i < 18; i++) off_arr[i] = pat ? 32'h0100 + i : int'($urandom_range(0, 65535));
      b_wr = n_wr; b_rv = n_refv; b_done = n_done; b_fall = n_fall; b_or = n_offrdy; b_zero = n_zero;

      @(posedge clk);
      #1;
      bus.start       = 1'b1;
      bus.bypass_mode = byp;
      start_cyc       = cyc;
      drive_src(fi, oi, pat);

      while (!fin && n < 3000) begin
         @(negedge clk);
         hsf = bus.feat_in_valid && bus.feat_in_ready;
         hso = bus.off_in_valid && bus.off_in_ready;
         @(posedge clk);
         #1;
         n++;
         if (hsf) fi++;
         if (hso) oi++;
         bus.start       = (!pat && $urandom_range(0, 49) == 0);
         bus.bypass_mode = 1'($urandom_range(0, 1));
         drive_src(fi, oi, pat);
         pushes = n_wr - b_wr;

         if (bp && full_left == 0 && ((pushes == 5 && !f5) || (pushes == 20 && !f20))) begin
            full_left = 3;
            if (pushes == 5) f5 = 1'b1;
            else f20 = 1'b1;
         end
         if (full_left > 0) begin
            bus.fifo_full = 1'b1;
            full_left--;
         end else begin
            bus.fifo_full = ($urandom_range(0, 99) < full_pct);
         end

         if (pushes < 34) begin
            bus.fifo_empty = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
         end else begin
            bus.fifo_empty = (cyc - last_push_cyc > hold);
            if (bus.fifo_empty && empty_cyc < 0) empty_cyc = cyc;
         end

         if (t6 && pushes == 20 && !mid_fired) begin
            bus.start = 1'b1;
            mid_fired = 1'b1;
         end
         if (bus.done) begin
            fin = 1'b1;
            if (t6) bus.start = 1'b1;
         end
         if (abort_at > 0 && (n_refv - b_rv) >= abort_at) begin
            bus.start = 1'b0;
            rst_n     = 1'b0;
            aborted   = 1'b1;
            fin       = 1'b1;
         end
      end

      if (aborted) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            drive_src(fi, oi, pat);
         end
         if (!fin) chk("tile_timeout", 0, 1);
         chk("push_count",      n_wr - b_wr, 34);
         chk("ref_valid_count", n_refv - b_rv, 256);
         chk("done_count",      n_done - b_done, 1);
         chk("busy_fall_count", n_fall - b_fall, 1);
         chk("first_word",      first_word, pat ? 32'h0001 : feat_arr[0]);
         if (pat && hold == 0) chk("tile_cycles", done_cyc - start_cyc, bp ? 300 : 294);
         if (byp) chk("off_ready_high", n_offrdy - b_or, 0);
         if (byp && pat) chk("zero_words", n_zero - b_zero, 18);
         if (hold > 0) chk("drain_to_ref", first_ref_cyc - empty_cyc, 2);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.bypass_mode = 1'b0;
      bus.feat_in = 16'h0000; bus.feat_in_valid = 1'b0;
      bus.off_in = 16'h0000; bus.off_in_valid = 1'b0;
      bus.fifo_full = 1'b0; bus.fifo_empty = 1'b1; bus.ref_rd_data = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_tile(1'b0, 1'b1, 0, 1'b0, 0,  1'b0, 40);   // reset in the middle of the ref stream
      run_tile(1'b0, 1'b1, 0, 1'b0, 0,  1'b0, 0);    // nominal, restarts from feature 0
      run_tile(1'b0, 1'b1, 0, 1'b1, 0,  1'b0, 0);    // FIFO full on words 5 and 20
      run_tile(1'b1, 1'b1, 0, 1'b0, 0,  1'b0, 0);    // bypass offsets
      run_tile(1'b0, 1'b1, 0, 1'b0, 50, 1'b0, 0);    // long drain
      run_tile(1'b0, 1'b1, 0, 1'b0, 0,  1'b1, 0);    // stray starts
      for (int t = 0; t < 6; t++) begin
         run_tile(1'($urandom_range(0, 1)), 1'b0, 25, 1'b0, int'($urandom_range(1, 6)), 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
